// File: rtl/core_gpio_pkg.sv
// rtl/core_gpio_pkg.sv - register map, CONFIG field positions and interrupt types for core_gpio
package core_gpio_pkg;

  localparam logic [7:0] OFF_INTR = 8'h80;
  localparam logic [7:0] OFF_IN   = 8'h90;
  localparam logic [7:0] OFF_OUT  = 8'hA0;

  localparam int CFG_OE   = 0;
  localparam int CFG_IE   = 1;
  localparam int CFG_DRV  = 2;
  localparam int CFG_INTE = 3;
  localparam int CFG_RSVD = 4;
  localparam int CFG_TYPE = 5;

  typedef enum logic [2:0] {
    INT_LEVEL_HIGH = 3'd0,
    INT_LEVEL_LOW  = 3'd1,
    INT_RISE       = 3'd2,
    INT_FALL       = 3'd3,
    INT_BOTH       = 3'd4,
    INT_OFF        = 3'd7
  } int_type_e;

  typedef enum logic [1:0] {
    IO_INPUT  = 2'd0,
    IO_OUTPUT = 2'd1,
    IO_BIDIR  = 2'd2
  } io_type_e;

  // A disabled interrupt type reads back as zero in the type field.
  function automatic logic [7:0] fixed_cfg(input logic [1:0] io, input logic [2:0] itype);
    logic en;
    en = (itype != INT_OFF);
    return {en ? itype : 3'd0, 1'b0, en, io != IO_INPUT, io != IO_OUTPUT, io != IO_INPUT};
  endfunction

endpackage

// File: rtl/core_gpio_bit.sv
// rtl/core_gpio_bit.sv - one GPIO: CONFIG register, input synchronizer, edge detect and INTR flag
module core_gpio_bit
  import core_gpio_pkg::*;
#(
  parameter bit         FIXED    = 1'b0,
  parameter logic [1:0] IO_TYPE  = 2'd0,
  parameter logic [2:0] INT_TYPE = 3'd7
) (
  input  logic       SYSCLK_apb,
  input  logic       PRESETN,
  input  logic       cfg_we,
  input  logic [7:0] cfg_wdata,
  input  logic       out_val,
  input  logic       intr_clr,
  input  logic       pin,
  output logic [7:0] cfg,
  output logic       in_val,
  output logic       gpio_out,
  output logic       gpio_oe,
  output logic       intr
);

  logic       s1, s2, prev, hit;
  logic [2:0] primed;
  int_type_e  itype;

  if (FIXED) begin : g_fixed
    logic unused_wr;
    assign unused_wr = ^{cfg_we, cfg_wdata};
    assign cfg = fixed_cfg(IO_TYPE, INT_TYPE);
  end else begin : g_rw
    logic [7:0] cfg_q;
    always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
      if (!PRESETN)    cfg_q <= '0;
      else if (cfg_we) cfg_q <= cfg_wdata & ~(8'(1) << CFG_RSVD);
    end
    assign cfg = cfg_q;
  end

  // primed[2] marks the point where s2 and prev both hold post-reset samples,
  // so pin history from before reset can never look like an edge.
  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      prev   <= 1'b0;
      primed <= '0;
    end else begin
      s1     <= pin;
      s2     <= s1;
      prev   <= s2;
      primed <= {primed[1:0], 1'b1};
    end
  end

  assign itype  = int_type_e'(cfg[CFG_TYPE+:3]);
  assign in_val = s2 & cfg[CFG_IE];

  always_comb begin
    hit = 1'b0;
    case (itype)
      INT_LEVEL_HIGH: hit = s2;
      INT_LEVEL_LOW:  hit = ~s2;
      INT_RISE:       hit = s2 & ~prev;
      INT_FALL:       hit = ~s2 & prev;
      INT_BOTH:       hit = s2 ^ prev;
      default:        hit = 1'b0;
    endcase
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      intr     <= 1'b0;
      gpio_out <= 1'b0;
      gpio_oe  <= 1'b0;
    end else begin
      intr     <= (cfg[CFG_INTE] & primed[2] & hit) | (intr & ~intr_clr);
      gpio_out <= out_val & cfg[CFG_OE];
      gpio_oe  <= cfg[CFG_DRV];
    end
  end

endmodule

// File: rtl/core_gpio.sv
// rtl/core_gpio.sv - APB GPIO block: address decode, lane mapping, OUT register, per-bit instances
module core_gpio
  import core_gpio_pkg::*;
#(
  parameter int          IO_NUM       = 32,
  parameter int          APB_WIDTH    = 32,
  parameter int          INT_BUS      = 1,
  parameter logic [31:0] FIXED_CONFIG = '0,
  parameter logic [63:0] IO_TYPE      = '0,
  parameter logic [95:0] IO_INT_TYPE  = {32{3'b111}}
) (
  input  logic                 SYSCLK_apb,
  input  logic                 PRESETN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [7:0]           PADDR,
  input  logic [APB_WIDTH-1:0] PWDATA,
  output logic [APB_WIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic [IO_NUM-1:0]    GPIO_IN,
  output logic [IO_NUM-1:0]    GPIO_OUT,
  output logic [IO_NUM-1:0]    GPIO_OE,
  output logic [IO_NUM-1:0]    INT,
  output logic                 INT_OR
);

  localparam int LANES = 32 / APB_WIDTH;

  logic                 wr, lane_ok, is_cfg, is_intr, is_in, is_out;
  logic [4:0]           cfg_idx, shift;
  logic [1:0]           lane;
  logic [IO_NUM-1:0]    lane_mask, wdata_lane, intr_clr;
  logic [IO_NUM-1:0]    in_vec, intr_vec, out_reg;
  logic [7:0]           cfg [IO_NUM];
  logic [APB_WIDTH-1:0] rword;

  assign wr      = PSEL & PENABLE & PWRITE;
  assign cfg_idx = PADDR[6:2];
  assign lane    = PADDR[3:2];
  assign shift   = 5'(lane * APB_WIDTH);
  assign lane_ok = (int'(lane) < LANES) && (PADDR[1:0] == 2'b00);
  assign is_cfg  = !PADDR[7] && (PADDR[1:0] == 2'b00) && (int'(cfg_idx) < IO_NUM);
  assign is_intr = (PADDR[7:4] == OFF_INTR[7:4]) && lane_ok;
  assign is_in   = (PADDR[7:4] == OFF_IN[7:4])   && lane_ok;
  assign is_out  = (PADDR[7:4] == OFF_OUT[7:4])  && lane_ok;

  // Narrow buses see the 32-bit registers as consecutive lanes, lowest bits first.
  assign lane_mask  = IO_NUM'(((64'd1 << APB_WIDTH) - 64'd1) << shift);
  assign wdata_lane = IO_NUM'(64'(PWDATA) << shift);
  assign intr_clr   = (wr && is_intr) ? (wdata_lane & lane_mask) : '0;

  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN)           out_reg <= '0;
    else if (wr && is_out)  out_reg <= (out_reg & ~lane_mask) | (wdata_lane & lane_mask);
  end

  for (genvar n = 0; n < IO_NUM; n++) begin : g_bit
    core_gpio_bit #(
      .FIXED    (FIXED_CONFIG[n]),
      .IO_TYPE  (IO_TYPE[2*n+:2]),
      .INT_TYPE (IO_INT_TYPE[3*n+:3])
    ) u_bit (
      .SYSCLK_apb (SYSCLK_apb),
      .PRESETN    (PRESETN),
      .cfg_we     (wr && is_cfg && (cfg_idx == 5'(n))),
      .cfg_wdata  (PWDATA[7:0]),
      .out_val    (out_reg[n]),
      .intr_clr   (intr_clr[n]),
      .pin        (GPIO_IN[n]),
      .cfg        (cfg[n]),
      .in_val     (in_vec[n]),
      .gpio_out   (GPIO_OUT[n]),
      .gpio_oe    (GPIO_OE[n]),
      .intr       (intr_vec[n])
    );
  end

  always_comb begin
    rword = '0;
    if (is_cfg) begin
      for (int i = 0; i < IO_NUM; i++)
        if (int'(cfg_idx) == i) rword = APB_WIDTH'(cfg[i]);
    end else if (is_intr) begin
      rword = APB_WIDTH'(32'(intr_vec) >> shift);
    end else if (is_in) begin
      rword = APB_WIDTH'(32'(in_vec) >> shift);
    end else if (is_out) begin
      rword = APB_WIDTH'(32'(out_reg) >> shift);
    end
  end

  assign PRDATA  = PSEL ? rword : '0;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign INT     = (INT_BUS != 0) ? intr_vec : '0;
  assign INT_OR  = |intr_vec;

endmodule

// File: tb/tb_core_gpio.sv
// tb/tb_core_gpio.sv - directed self-checking bench for core_gpio (8-bit/32-bit APB and 16-bit/8-bit APB builds)
module tb_core_gpio;

  logic        SYSCLK_apb;
  logic        rstn_a, psel_a, penable_a, pwrite_a;
  logic [7:0]  paddr_a;
  logic [31:0] pwdata_a, prdata_a;
  logic        pready_a, pslverr_a, int_or_a;
  logic [7:0]  gin_a, gout_a, goe_a, int_a;

  logic        rstn_b, psel_b, penable_b, pwrite_b;
  logic [7:0]  paddr_b, pwdata_b, prdata_b;
  logic        pready_b, pslverr_b, int_or_b;
  logic [15:0] gin_b, gout_b, goe_b, int_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  core_gpio #(
    .IO_NUM(8), .APB_WIDTH(32), .INT_BUS(1),
    .FIXED_CONFIG(32'h0000_0010), .IO_TYPE(64'h100)
  ) dut_a (
    .SYSCLK_apb(SYSCLK_apb), .PRESETN(rstn_a), .PSEL(psel_a), .PENABLE(penable_a),
    .PWRITE(pwrite_a), .PADDR(paddr_a), .PWDATA(pwdata_a), .PRDATA(prdata_a),
    .PREADY(pready_a), .PSLVERR(pslverr_a), .GPIO_IN(gin_a), .GPIO_OUT(gout_a),
    .GPIO_OE(goe_a), .INT(int_a), .INT_OR(int_or_a)
  );

  core_gpio #(.IO_NUM(16), .APB_WIDTH(8)) dut_b (
    .SYSCLK_apb(SYSCLK_apb), .PRESETN(rstn_b), .PSEL(psel_b), .PENABLE(penable_b),
    .PWRITE(pwrite_b), .PADDR(paddr_b), .PWDATA(pwdata_b), .PRDATA(prdata_b),
    .PREADY(pready_b), .PSLVERR(pslverr_b), .GPIO_IN(gin_b), .GPIO_OUT(gout_b),
    .GPIO_OE(goe_b), .INT(int_b), .INT_OR(int_or_b)
  );

  initial SYSCLK_apb = 1'b0;
  always #5 SYSCLK_apb = ~SYSCLK_apb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge SYSCLK_apb);
      #1;
    end
  endtask

  task automatic wr_a(input logic [7:0] a, input logic [31:0] d);
    @(posedge SYSCLK_apb); #1;
    psel_a = 1'b1; pwrite_a = 1'b1; paddr_a = a; pwdata_a = d; penable_a = 1'b0;
    tick(1);
    penable_a = 1'b1;
    tick(1);
    psel_a = 1'b0; penable_a = 1'b0; pwrite_a = 1'b0;
  endtask

  task automatic rd_a(input logic [7:0] a, output logic [31:0] d);
    @(negedge SYSCLK_apb);
    psel_a = 1'b1; pwrite_a = 1'b0; paddr_a = a;
    #1 d = prdata_a;
    psel_a = 1'b0;
  endtask

  task automatic wr_b(input logic [7:0] a, input logic [7:0] d);
    @(posedge SYSCLK_apb); #1;
    psel_b = 1'b1; pwrite_b = 1'b1; paddr_b = a; pwdata_b = d; penable_b = 1'b0;
    tick(1);
    penable_b = 1'b1;
    tick(1);
    psel_b = 1'b0; penable_b = 1'b0; pwrite_b = 1'b0;
  endtask

  task automatic rd_b(input logic [7:0] a, output logic [31:0] d);
    @(negedge SYSCLK_apb);
    psel_b = 1'b1; pwrite_b = 1'b0; paddr_b = a;
    #1 d = 32'(prdata_b);
    psel_b = 1'b0;
  endtask

  initial begin
    rstn_a = 1'b0; psel_a = 1'b0; penable_a = 1'b0; pwrite_a = 1'b0; paddr_a = '0; pwdata_a = '0; gin_a = '0;
    rstn_b = 1'b0; psel_b = 1'b0; penable_b = 1'b0; pwrite_b = 1'b0; paddr_b = '0; pwdata_b = '0; gin_b = '0;
    tick(2);
    check("rst_gpio_out", 32'(gout_a), 32'h0);
    check("rst_gpio_oe", 32'(goe_a), 32'h0);
    check("rst_int_or", 32'(int_or_a), 32'h0);
    check("pready", 32'({pready_a, pslverr_a}), 32'h2);
    rd_a(8'h00, rd); check("rst_cfg0", rd, 32'h0);
    @(posedge SYSCLK_apb); #1;
    rstn_a = 1'b1; rstn_b = 1'b1;
    tick(4);

    // Output path and registered latency
    wr_a(8'h00, 32'h05);
    tick(1);
    check("oe_after_cfg", 32'(goe_a), 32'h11);
    wr_a(8'hA0, 32'h01);
    check("out_one_edge_late", 32'(gout_a), 32'h00);
    tick(1);
    check("gpio_out0", 32'(gout_a), 32'h01);
    rd_a(8'h00, rd); check("rd_cfg0", rd, 32'h05);

    // Rising-edge interrupt on bit 1: sets on the third edge
    wr_a(8'h04, 32'h4A);
    gin_a = 8'h02;
    tick(2);
    check("rise_not_yet", 32'(int_a), 32'h0);
    tick(1);
    check("rise_int", 32'(int_a), 32'h02);
    check("rise_int_or", 32'(int_or_a), 32'h1);
    rd_a(8'h80, rd); check("rd_intr_rise", rd, 32'h02);
    wr_a(8'h80, 32'h02);
    check("clr_int_or", 32'(int_or_a), 32'h0);
    rd_a(8'h80, rd); check("rd_intr_clr", rd, 32'h0);

    // Level-low on bit 2: clear loses to set while low, sticks once high
    wr_a(8'h08, 32'h2A);
    tick(1);
    rd_a(8'h80, rd); check("level_set", rd, 32'h04);
    wr_a(8'h80, 32'h04);
    rd_a(8'h80, rd); check("level_reset_after_clr", rd, 32'h04);
    gin_a = 8'h06;
    tick(3);
    wr_a(8'h80, 32'h04);
    tick(2);
    rd_a(8'h80, rd); check("level_cleared", rd, 32'h0);

    // Input enable gating
    gin_a = 8'hFF;
    tick(2);
    rd_a(8'h90, rd); check("in_bit3_disabled", rd, 32'h06);
    wr_a(8'h0C, 32'h02);
    rd_a(8'h90, rd); check("in_bit3_enabled", rd, 32'h0E);
    rd_a(8'h80, rd); check("no_spurious_intr", rd, 32'h0);

    // Fixed CONFIG_4 and unmapped space
    wr_a(8'h10, 32'hFF);
    rd_a(8'h10, rd); check("fixed_cfg4", rd, 32'h05);
    wr_a(8'hA0, 32'h11);
    tick(1);
    check("fixed_out4", 32'(gout_a), 32'h11);
    wr_a(8'h20, 32'hFF);
    rd_a(8'h20, rd); check("cfg8_unmapped", rd, 32'h0);
    wr_a(8'hA4, 32'hFF);
    rd_a(8'hA4, rd); check("out_lane1_unmapped", rd, 32'h0);
    rd_a(8'hA0, rd); check("out_unchanged", rd, 32'h11);
    rd_a(8'h14, rd); check("cfg5_default", rd, 32'h0);

    // 8-bit bus, 16 IOs: lane mapping
    wr_b(8'h3C, 8'h05);
    tick(1);
    check("b_oe15", 32'(goe_b), 32'h8000);
    wr_b(8'hA4, 8'h80);
    tick(1);
    check("b_out15", 32'(gout_b), 32'h8000);
    rd_b(8'hA4, rd); check("b_rd_out_lane1", rd, 32'h80);
    wr_b(8'hA0, 8'hFF);
    tick(1);
    check("b_out_gated", 32'(gout_b), 32'h8000);
    rd_b(8'hA0, rd); check("b_rd_out_lane0", rd, 32'hFF);
    wr_b(8'h3C, 8'h04);
    tick(1);
    check("b_out15_off", 32'(gout_b), 32'h0000);
    check("b_oe15_kept", 32'(goe_b), 32'h8000);
    wr_b(8'h3C, 8'h05);
    tick(1);
    check("b_out15_on", 32'(gout_b), 32'h8000);

    wr_b(8'h00, 8'h4A);
    gin_b = 16'h0001;
    tick(3);
    check("b_int0", 32'(int_b), 32'h0001);
    rd_b(8'h80, rd); check("b_rd_intr_lane0", rd, 32'h01);
    rd_b(8'h84, rd); check("b_rd_intr_lane1", rd, 32'h00);

    // Mid-test reset clears outputs asynchronously; pre-reset pin state raises no edge
    rstn_b = 1'b0;
    #1;
    check("b_rst_out", 32'(gout_b), 32'h0);
    check("b_rst_oe", 32'(goe_b), 32'h0);
    check("b_rst_int", 32'({int_or_b, int_b}), 32'h0);
    rd_b(8'h3C, rd); check("b_rst_cfg15", rd, 32'h0);
    @(posedge SYSCLK_apb); #1;
    rstn_b = 1'b1;
    wr_b(8'h00, 8'h4A);
    tick(4);
    check("b_no_stale_edge", 32'(int_or_b), 32'h0);
    gin_b = 16'h0000;
    tick(3);
    gin_b = 16'h0001;
    tick(3);
    check("b_fresh_edge", 32'(int_or_b), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
